// File: rtl/lcd_char_pkg.sv
// Shared constants and helpers for the HD44780-style character LCD emulator:
// instruction bit positions, DDRAM bank layout and address-counter stepping.
package lcd_char_pkg;

  localparam int BIT_SET_DD = 7;
  localparam int BIT_SET_CG = 6;
  localparam int BIT_FSET   = 5;
  localparam int BIT_SHIFT  = 4;
  localparam int BIT_DISP   = 3;
  localparam int BIT_ENTRY  = 2;
  localparam int BIT_HOME   = 1;
  localparam int BIT_CLEAR  = 0;
  localparam int BIT_DL     = 4;
  localparam int BIT_SC     = 3;
  localparam int BIT_RL     = 2;
  localparam int BIT_ID     = 1;

  localparam logic [6:0] BANK0_BASE = 7'h00;
  localparam logic [6:0] BANK0_END  = 7'h27;
  localparam logic [6:0] BANK1_BASE = 7'h40;
  localparam logic [6:0] BANK1_END  = 7'h67;
  localparam logic [7:0] SPACE      = 8'h20;
  localparam int         DD_SIZE    = 80;
  localparam int         CG_SIZE    = 64;

  typedef enum logic [3:0] {
    OP_NOP, OP_SET_DD, OP_SET_CG, OP_FSET, OP_SHIFT,
    OP_DISP, OP_ENTRY, OP_HOME, OP_CLEAR
  } op_e;

  // Highest set bit selects the instruction.
  function automatic op_e decode(logic [7:0] b);
    if (b[BIT_SET_DD]) return OP_SET_DD;
    if (b[BIT_SET_CG]) return OP_SET_CG;
    if (b[BIT_FSET])   return OP_FSET;
    if (b[BIT_SHIFT])  return OP_SHIFT;
    if (b[BIT_DISP])   return OP_DISP;
    if (b[BIT_ENTRY])  return OP_ENTRY;
    if (b[BIT_HOME])   return OP_HOME;
    if (b[BIT_CLEAR])  return OP_CLEAR;
    return OP_NOP;
  endfunction

  function automatic logic dd_valid(logic [6:0] a);
    return (a <= BANK0_END) || (a >= BANK1_BASE && a <= BANK1_END);
  endfunction

  // Packs the two 40-byte banks into one contiguous 0..79 index.
  function automatic logic [6:0] dd_idx(logic [6:0] a);
    return a[6] ? 7'd40 + {1'b0, a[5:0]} : a;
  endfunction

  function automatic logic [6:0] step_ac(logic [6:0] a, logic inc, logic cg);
    if (cg)  return {1'b0, inc ? a[5:0] + 6'd1 : a[5:0] - 6'd1};
    if (inc) return (a == BANK0_END) ? BANK1_BASE : (a == BANK1_END) ? BANK0_BASE : a + 7'd1;
    return (a == BANK0_BASE) ? BANK1_END : (a == BANK1_BASE) ? BANK0_END : a - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// DDRAM (80 B, two banks) and CGRAM (64 B) storage together with the address
// counter and the DDRAM/CGRAM target selection.
module lcd_char_ram
  import lcd_char_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set_ac,
  input  logic [6:0] ac_new,
  input  logic       cg_new,
  input  logic       wr,
  input  logic [7:0] wdata,
  input  logic       step,
  input  logic       inc,
  input  logic       clr,
  input  logic [6:0] disp_addr,
  output logic [6:0] ac,
  output logic       cg,
  output logic [7:0] rdata,
  output logic [7:0] disp_char
);

  logic [7:0] dd  [DD_SIZE];
  logic [7:0] cgr [CG_SIZE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ac <= '0;
      cg <= 1'b0;
      for (int i = 0; i < DD_SIZE; i++) dd[i]  <= SPACE;
      for (int i = 0; i < CG_SIZE; i++) cgr[i] <= 8'h00;
    end else if (clr) begin
      ac <= '0;
      for (int i = 0; i < DD_SIZE; i++) dd[i] <= SPACE;
    end else if (set_ac) begin
      ac <= ac_new;
      cg <= cg_new;
    end else begin
      // Writes land at the current AC; the step is applied afterwards.
      if (wr) begin
        if (cg)                cgr[ac[5:0]]   <= wdata;
        else if (dd_valid(ac)) dd[dd_idx(ac)] <= wdata;
      end
      if (step) ac <= step_ac(ac, inc, cg);
    end
  end

  assign rdata     = cg ? cgr[ac[5:0]] : (dd_valid(ac) ? dd[dd_idx(ac)] : SPACE);
  assign disp_char = dd_valid(disp_addr) ? dd[dd_idx(disp_addr)] : SPACE;

endmodule

// File: rtl/lcd_char_emul.sv
// Character LCD controller emulator: bus sampling on the falling edge of EN,
// 4/8-bit byte assembly, instruction decode, busy timing and display readout.
module lcd_char_emul
  import lcd_char_pkg::*;
#(
  parameter int G_NB_LINES         = 2,
  parameter int G_NB_COLS          = 16,
  parameter int G_BUSY_CYCLES      = 8,
  parameter int G_BUSY_LONG_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rs,
  input  logic       i_rw,
  input  logic       i_en,
  inout  wire  [7:0] io_data,
  input  logic [1:0] i_disp_line,
  input  logic [5:0] i_disp_col,
  output logic [7:0] o_disp_char,
  output logic [7:0] o_instr,
  output logic       o_instr_val,
  output logic       o_err_busy,
  output logic       o_busy,
  output logic [6:0] o_ac,
  output logic       o_mode4
);

  localparam int         CW = $clog2(G_BUSY_LONG_CYCLES + G_BUSY_CYCLES + 1);
  localparam logic [2:0] NL = 3'(G_NB_LINES);
  localparam logic [6:0] NC = 7'(G_NB_COLS);

  logic          en_q, mode4, tog, p_rs, p_rw, id;
  logic [3:0]    hi_nib;
  logic [CW-1:0] cnt;
  logic          fall, done, bf, req, exec, err;
  logic [7:0]    b, rdata, rd_byte, drv, disp_raw;
  op_e           op;
  logic [6:0]    ac, ac_new, disp_addr;
  logic          cg, cg_new, set_ac, wr, step, inc, clr;

  assign fall = en_q & ~i_en;
  assign bf   = (cnt != '0);

  // Byte assembly: the second nibble only completes if RS/RW held steady.
  always_comb begin
    done = 1'b0;
    b    = io_data;
    if (fall) begin
      if (!mode4) done = 1'b1;
      else if (tog && p_rs == i_rs && p_rw == i_rw) begin
        done = 1'b1;
        b    = {hi_nib, io_data[7:4]};
      end
    end
  end

  assign op   = decode(b);
  assign req  = done && !i_rw && (i_rs || op != OP_NOP);
  assign exec = req && !bf;
  assign err  = req && bf;

  always_comb begin
    set_ac = 1'b0;
    ac_new = '0;
    cg_new = cg;
    wr     = 1'b0;
    step   = 1'b0;
    inc    = id;
    clr    = 1'b0;
    if (exec && i_rs) begin
      wr   = 1'b1;
      step = 1'b1;
    end else if (exec) begin
      case (op)
        OP_SET_DD: begin set_ac = 1'b1; ac_new = b[6:0]; cg_new = 1'b0; end
        OP_SET_CG: begin set_ac = 1'b1; ac_new = {1'b0, b[5:0]}; cg_new = 1'b1; end
        OP_SHIFT:  begin step = !b[BIT_SC]; inc = b[BIT_RL]; end
        OP_HOME:   set_ac = 1'b1;
        OP_CLEAR:  clr = 1'b1;
        default:   ;
      endcase
    end else if (done && i_rs && i_rw) begin
      step = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q        <= 1'b0;
      mode4       <= 1'b0;
      tog         <= 1'b0;
      hi_nib      <= '0;
      p_rs        <= 1'b0;
      p_rw        <= 1'b0;
      id          <= 1'b1;
      cnt         <= '0;
      o_instr     <= '0;
      o_instr_val <= 1'b0;
      o_err_busy  <= 1'b0;
    end else begin
      en_q        <= i_en;
      o_instr_val <= exec;
      o_err_busy  <= err;
      if (fall && mode4) begin
        if (!tog) begin
          tog    <= 1'b1;
          hi_nib <= io_data[7:4];
          p_rs   <= i_rs;
          p_rw   <= i_rw;
        end else begin
          tog <= 1'b0;
        end
      end
      if (exec) begin
        o_instr <= b;
        cnt     <= (!i_rs && (op == OP_HOME || op == OP_CLEAR)) ?
                   CW'(G_BUSY_LONG_CYCLES) : CW'(G_BUSY_CYCLES);
        if (!i_rs && op == OP_FSET)  mode4 <= ~b[BIT_DL];
        if (!i_rs && op == OP_ENTRY) id    <= b[BIT_ID];
        if (!i_rs && op == OP_CLEAR) id    <= 1'b1;
      end else if (bf) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  lcd_char_ram u_ram (
    .clk       (clk),
    .rst       (rst),
    .set_ac    (set_ac),
    .ac_new    (ac_new),
    .cg_new    (cg_new),
    .wr        (wr),
    .wdata     (b),
    .step      (step),
    .inc       (inc),
    .clr       (clr),
    .disp_addr (disp_addr),
    .ac        (ac),
    .cg        (cg),
    .rdata     (rdata),
    .disp_char (disp_raw)
  );

  // In 4-bit mode the selected half rides on D7..D4.
  assign rd_byte = i_rs ? rdata : {bf, ac};
  assign drv     = !mode4 ? rd_byte : {(tog ? rd_byte[3:0] : rd_byte[7:4]), 4'h0};
  assign io_data = (i_rw && i_en) ? drv : 8'hzz;

  assign disp_addr   = (i_disp_line[0] ? BANK1_BASE : BANK0_BASE)
                     + (i_disp_line[1] ? NC : 7'd0) + {1'b0, i_disp_col};
  assign o_disp_char = ({1'b0, i_disp_line} < NL && {1'b0, i_disp_col} < NC) ? disp_raw : SPACE;

  assign o_busy  = bf;
  assign o_ac    = ac;
  assign o_mode4 = mode4;

endmodule
